// File: rtl/ysyx_23060203_axi_pkg.sv
// Shared AXI definitions: burst encodings, response codes, responder FSM states
// and the burst-legality check used by the responders.
package ysyx_23060203_axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b001,
        ST_WAIT  = 3'b010,
        ST_BURST = 3'b100
    } state_t;

    // Whole-burst error: beat wider than the 64-bit bus, reserved burst type,
    // or a WRAP whose length is not 2/4/8/16 beats.
    function automatic logic burst_err(input logic [2:0] size,
                                       input logic [1:0] burst,
                                       input logic [7:0] len);
        logic bad_wrap;
        bad_wrap = (burst == BURST_WRAP) &&
                   !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
        return (size > 3'd3) || (burst == 2'b11) || bad_wrap;
    endfunction

endpackage

// File: rtl/ysyx_23060203_axi_burst_addr.sv
// Combinational AXI next-beat address: FIXED holds, INCR steps by the beat size,
// WRAP steps inside the naturally aligned (len+1)<<size window.
module ysyx_23060203_axi_burst_addr
    import ysyx_23060203_axi_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [2:0]  size,
    input  logic [7:0]  len,
    input  logic [1:0]  burst,
    output logic [31:0] next_addr
);

    logic [31:0] step;
    logic [31:0] span;
    logic [31:0] wrap_mask;
    logic [31:0] sum;
    logic [31:0] wrap_addr;

    assign step      = 32'd1 << size;
    assign span      = ({24'd0, len} + 32'd1) << size;
    assign wrap_mask = span - 32'd1;
    assign sum       = addr + step;

    // Bits inside the wrap window come from the incremented address, the rest stay put.
    for (genvar gi = 0; gi < 32; gi++) begin : g_wrap_bit
        assign wrap_addr[gi] = wrap_mask[gi] ? sum[gi] : addr[gi];
    end

    always_comb begin
        next_addr = addr;
        if (burst == BURST_INCR) begin
            next_addr = sum;
        end else if (burst == BURST_WRAP) begin
            next_addr = wrap_addr;
        end
    end

endmodule

// File: rtl/ysyx_23060203_axi_rd_responder.sv
// AXI4 read responder (AR/R) over a local 64-bit memory array with a preload
// side port; one outstanding burst, configurable first-beat latency.
module ysyx_23060203_axi_rd_responder
    import ysyx_23060203_axi_pkg::*;
#(
    parameter logic [31:0] BASE      = 32'h8000_0000,
    parameter int          MEM_BYTES = 65536,
    parameter int          LAT       = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        s_r_arvalid,
    output logic        s_r_arready,
    input  logic [31:0] s_r_araddr,
    input  logic [3:0]  s_r_arid,
    input  logic [7:0]  s_r_arlen,
    input  logic [2:0]  s_r_arsize,
    input  logic [1:0]  s_r_arburst,
    output logic        s_r_rvalid,
    input  logic        s_r_rready,
    output logic [63:0] s_r_rdata,
    output logic [1:0]  s_r_rresp,
    output logic        s_r_rlast,
    output logic [3:0]  s_r_rid,
    input  logic        init_we,
    input  logic [31:0] init_addr,
    input  logic [63:0] init_data
);

    localparam int WORDS = MEM_BYTES / 8;
    localparam int AW    = $clog2(MEM_BYTES);
    localparam int LW    = (LAT > 0) ? $clog2(LAT + 1) : 1;
    localparam logic [LW-1:0] LAT_START = (LAT > 0) ? LW'(LAT - 1) : '0;

    state_t        state_reg, state_next;
    logic [LW-1:0] lat_cnt_reg;
    logic [7:0]    beat_cnt_reg;
    logic [31:0]   addr_reg;
    logic [3:0]    id_reg;
    logic [7:0]    len_reg;
    logic [2:0]    size_reg;
    logic [1:0]    burst_reg;
    logic          rvalid_reg;
    logic          rlast_reg;
    logic [3:0]    rid_reg;
    logic [1:0]    rresp_reg;
    logic          data_ok_reg;
    logic [63:0]   mem_rd_reg;
    logic [63:0]   mem [0:WORDS-1];

    logic          ar_hs;
    logic          r_hs;
    logic          load;
    logic          from_ar;
    logic [31:0]   cur_addr;
    logic [3:0]    cur_id;
    logic [7:0]    cur_len;
    logic [2:0]    cur_size;
    logic [1:0]    cur_burst;
    logic [7:0]    cur_idx;
    logic [31:0]   next_addr;
    logic [31:0]   offset;
    logic [31:0]   init_off;
    logic          in_range;
    logic          err;

    assign s_r_arready = (state_reg == ST_IDLE);
    assign ar_hs       = s_r_arvalid && s_r_arready;
    assign r_hs        = rvalid_reg && s_r_rready;

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (ar_hs) begin
                    if (LAT == 0) begin
                        state_next = ST_BURST;
                        load       = 1'b1;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (lat_cnt_reg == '0) begin
                    state_next = ST_BURST;
                    load       = 1'b1;
                end
            end
            ST_BURST: begin
                if (r_hs) begin
                    if (rlast_reg) begin
                        state_next = ST_IDLE;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // With LAT=0 the first beat loads on the AR edge itself, so take the fields straight off AR.
    assign from_ar   = (state_reg == ST_IDLE);
    assign cur_addr  = from_ar ? s_r_araddr  : addr_reg;
    assign cur_id    = from_ar ? s_r_arid    : id_reg;
    assign cur_len   = from_ar ? s_r_arlen   : len_reg;
    assign cur_size  = from_ar ? s_r_arsize  : size_reg;
    assign cur_burst = from_ar ? s_r_arburst : burst_reg;
    assign cur_idx   = (state_reg == ST_BURST) ? beat_cnt_reg + 8'd1 : 8'd0;

    assign offset    = cur_addr - BASE;
    assign init_off  = init_addr - BASE;
    assign in_range  = offset < 32'(MEM_BYTES);
    assign err       = burst_err(cur_size, cur_burst, cur_len);

    ysyx_23060203_axi_burst_addr u_burst_addr (
        .addr      (cur_addr),
        .size      (cur_size),
        .len       (cur_len),
        .burst     (cur_burst),
        .next_addr (next_addr)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            lat_cnt_reg  <= '0;
            beat_cnt_reg <= 8'd0;
            addr_reg     <= 32'd0;
            id_reg       <= 4'd0;
            len_reg      <= 8'd0;
            size_reg     <= 3'd0;
            burst_reg    <= 2'd0;
            rvalid_reg   <= 1'b0;
            rlast_reg    <= 1'b0;
            rid_reg      <= 4'd0;
            rresp_reg    <= RESP_OKAY;
            data_ok_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (ar_hs) begin
                addr_reg    <= s_r_araddr;
                id_reg      <= s_r_arid;
                len_reg     <= s_r_arlen;
                size_reg    <= s_r_arsize;
                burst_reg   <= s_r_arburst;
                lat_cnt_reg <= LAT_START;
            end
            if ((state_reg == ST_WAIT) && (lat_cnt_reg != '0)) begin
                lat_cnt_reg <= lat_cnt_reg - 1'b1;
            end
            if (load) begin
                addr_reg     <= next_addr;
                beat_cnt_reg <= cur_idx;
                rlast_reg    <= (cur_idx == cur_len);
                rid_reg      <= cur_id;
                rresp_reg    <= err ? RESP_SLVERR : (in_range ? RESP_OKAY : RESP_DECERR);
                data_ok_reg  <= !err && in_range;
                rvalid_reg   <= 1'b1;
            end else if (r_hs && rlast_reg) begin
                rvalid_reg <= 1'b0;
            end
        end
    end

    // Read-before-write: a beat loaded in the same cycle as a preload sees the old word.
    always_ff @(posedge clock) begin
        if (init_we) begin
            mem[init_off[AW-1:3]] <= init_data;
        end
        if (load) begin
            mem_rd_reg <= mem[offset[AW-1:3]];
        end
    end

    assign s_r_rvalid = rvalid_reg;
    assign s_r_rlast  = rlast_reg;
    assign s_r_rid    = rid_reg;
    assign s_r_rresp  = rresp_reg;
    assign s_r_rdata  = data_ok_reg ? mem_rd_reg : 64'd0;

endmodule

// File: tb/tb_ysyx_23060203_axi_rd_responder.sv
// Scoreboard bench: AR issue pushes the model's expected beats, a negedge monitor
// pops and compares every R handshake; second instance covers the LAT=0 build.
module tb_ysyx_23060203_axi_rd_responder;

    localparam logic [31:0] BASE      = 32'h8000_0000;
    localparam int          MEM_BYTES = 65536;
    localparam int          WORDS     = MEM_BYTES / 8;
    localparam int          LAT       = 2;
    localparam int          Z_BYTES   = 256;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
        int          cyc;
    } beat_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic        arvalid = 0, arready, rvalid, rready = 0, rlast, init_we = 0;
    logic [31:0] araddr = 0, init_addr = 0;
    logic [3:0]  arid = 0, rid;
    logic [7:0]  arlen = 0;
    logic [2:0]  arsize = 0;
    logic [1:0]  arburst = 0, rresp;
    logic [63:0] rdata, init_data = 0;

    logic        z_arvalid = 0, z_arready, z_rvalid, z_rready = 1, z_rlast, z_init_we = 0;
    logic [31:0] z_araddr = 0, z_init_addr = 0;
    logic [3:0]  z_arid = 0, z_rid;
    logic [7:0]  z_arlen = 0;
    logic [2:0]  z_arsize = 0;
    logic [1:0]  z_arburst = 0, z_rresp;
    logic [63:0] z_rdata, z_init_data = 0;

    ysyx_23060203_axi_rd_responder #(.BASE(BASE), .MEM_BYTES(MEM_BYTES), .LAT(LAT)) dut (
        .clock(clock), .reset(reset),
        .s_r_arvalid(arvalid), .s_r_arready(arready), .s_r_araddr(araddr), .s_r_arid(arid),
        .s_r_arlen(arlen), .s_r_arsize(arsize), .s_r_arburst(arburst),
        .s_r_rvalid(rvalid), .s_r_rready(rready), .s_r_rdata(rdata), .s_r_rresp(rresp),
        .s_r_rlast(rlast), .s_r_rid(rid),
        .init_we(init_we), .init_addr(init_addr), .init_data(init_data)
    );

    ysyx_23060203_axi_rd_responder #(.BASE(BASE), .MEM_BYTES(Z_BYTES), .LAT(0)) dut0 (
        .clock(clock), .reset(reset),
        .s_r_arvalid(z_arvalid), .s_r_arready(z_arready), .s_r_araddr(z_araddr), .s_r_arid(z_arid),
        .s_r_arlen(z_arlen), .s_r_arsize(z_arsize), .s_r_arburst(z_arburst),
        .s_r_rvalid(z_rvalid), .s_r_rready(z_rready), .s_r_rdata(z_rdata), .s_r_rresp(z_rresp),
        .s_r_rlast(z_rlast), .s_r_rid(z_rid),
        .init_we(z_init_we), .init_addr(z_init_addr), .init_data(z_init_data)
    );

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          beats_seen = 0;
    int          rready_mode = 0;
    bit          busy = 0;
    bit          chk_timing = 0;
    logic [63:0] ref_mem [0:WORDS-1];
    beat_t       exp_q[$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: beat addresses straight from the AXI burst rules.
    task automatic push_burst(input logic [31:0] start, input logic [3:0] id, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst, input int hs);
        longint unsigned bytes, span, lower, a;
        bit bad;
        beat_t e;
        bytes = longint'(1) << size;
        span  = (longint'(len) + 1) * bytes;
        lower = (longint'(start) / span) * span;
        bad   = (size > 3) || (burst == 2'b11) ||
                (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15));
        for (int i = 0; i <= int'(len); i++) begin
            case (burst)
                2'b00:   a = start;
                2'b01:   a = (longint'(start) + i * bytes) & 64'hFFFF_FFFF;
                default: a = lower + ((longint'(start) - lower + i * bytes) % span);
            endcase
            e.id   = id;
            e.last = (i == int'(len));
            e.cyc  = chk_timing ? hs + LAT + 1 + i : -1;
            if (bad) begin
                e.resp = 2'b10;
                e.data = 64'd0;
            end else if (a >= longint'(BASE) && a < longint'(BASE) + MEM_BYTES) begin
                e.resp = 2'b00;
                e.data = ref_mem[int'((a - longint'(BASE)) >> 3)];
            end else begin
                e.resp = 2'b11;
                e.data = 64'd0;
            end
            exp_q.push_back(e);
        end
    endtask

    // Monitor: arready vs. outstanding burst, stall stability, and scoreboard pops.
    logic [63:0] p_data;
    logic [1:0]  p_resp;
    logic        p_last;
    logic [3:0]  p_id;
    bit          p_stall = 0;
    always @(negedge clock) begin
        beat_t e;
        if (!reset) begin
            chk("arready", {63'd0, arready}, {63'd0, !busy});
            if (p_stall) begin
                chk("stall_rvalid", {63'd0, rvalid}, 64'd1);
                chk("stall_rdata", rdata, p_data);
                chk("stall_rside", {57'd0, rlast, rresp, rid}, {57'd0, p_last, p_resp, p_id});
            end
            p_stall = rvalid && !rready;
            p_data  = rdata;
            p_resp  = rresp;
            p_last  = rlast;
            p_id    = rid;
            if (arvalid && arready) begin
                busy = 1;
                push_burst(araddr, arid, arlen, arsize, arburst, cyc);
            end
            if (rvalid && rready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got rdata %h rresp %0d with no beat expected", rdata, rresp);
                end else begin
                    e = exp_q.pop_front();
                    chk("rdata", rdata, e.data);
                    chk("rresp", {62'd0, rresp}, {62'd0, e.resp});
                    chk("rlast", {63'd0, rlast}, {63'd0, e.last});
                    chk("rid", {60'd0, rid}, {60'd0, e.id});
                    if (e.cyc >= 0) chk("beat_cycle", 64'(cyc), 64'(e.cyc));
                end
                beats_seen++;
                if (rlast) busy = 0;
            end
        end else begin
            p_stall = 0;
        end
    end

    initial begin
        forever begin
            @(posedge clock);
            #1;
            case (rready_mode)
                0:       rready = 1'b1;
                1:       rready = ~rready;
                default: rready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic issue_ar(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        bit ok = 0;
        @(posedge clock);
        #1;
        araddr = a; arid = id; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clock);
            if (arready) begin
                ok = 1;
                break;
            end
        end
        @(posedge clock);
        #1 arvalid = 1'b0;
        if (!ok) chk("ar_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clock);
            if (exp_q.size() == 0 && !busy) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        logic [1:0] b;
        logic [2:0] sz;
        logic [7:0] ln;
        logic [31:0] a;
        logic [63:0] z_old, z_new;

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_arready", {63'd0, arready}, 64'd1);
        chk("reset_rvalid", {63'd0, rvalid}, 64'd0);
        chk("reset_rside", {57'd0, rlast, rresp, rid}, 64'd0);
        chk("reset_rdata", rdata, 64'd0);
        @(posedge clock);
        #1 reset = 1'b0;

        for (int i = 0; i < WORDS; i++) begin
            @(posedge clock);
            #1;
            ref_mem[i] = {$urandom, $urandom};
            init_we = 1'b1; init_addr = BASE + 32'(i * 8); init_data = ref_mem[i];
        end
        @(posedge clock);
        #1 init_we = 1'b0;

        rready_mode = 0;
        chk_timing = 1;
        issue_ar(BASE, 4'd5, 8'd1, 3'd3, 2'b01);
        wait_idle();
        chk_timing = 0;

        issue_ar(BASE + 32'h8, 4'd6, 8'd3, 3'd2, 2'b10);
        wait_idle();

        rready_mode = 1;
        s = beats_seen;
        issue_ar(BASE + 32'h40, 4'd7, 8'd7, 3'd3, 2'b01);
        wait_idle();
        chk("stall_handshakes", 64'(beats_seen - s), 64'd8);

        rready_mode = 0;
        issue_ar(BASE + 32'(MEM_BYTES) - 32'd8, 4'd8, 8'd1, 3'd3, 2'b01);
        wait_idle();
        issue_ar(BASE, 4'd9, 8'd2, 3'd4, 2'b01);
        wait_idle();

        rready_mode = 2;
        for (int t = 0; t < 40; t++) begin
            s  = $urandom_range(0, 9);
            b  = (s < 2) ? 2'b00 : (s < 6) ? 2'b01 : (s < 9) ? 2'b10 : 2'b11;
            sz = ($urandom_range(0, 9) == 0) ? 3'd4 : 3'($urandom_range(0, 3));
            if (b == 2'b10) ln = ($urandom_range(0, 4) == 0) ? 8'd2 : 8'((2 << $urandom_range(0, 3)) - 1);
            else            ln = 8'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0, 1:    a = BASE + 32'($urandom_range(0, 255));
                2:       a = BASE + 32'(MEM_BYTES) - 32'd32 + 32'($urandom_range(0, 31));
                default: a = BASE - 32'd16 + 32'($urandom_range(0, 15));
            endcase
            issue_ar(a, 4'($urandom_range(0, 15)), ln, sz, b);
        end
        wait_idle();

        rready_mode = 0;
        s = beats_seen;
        issue_ar(BASE + 32'h80, 4'd3, 8'd3, 3'd3, 2'b01);
        for (int k = 0; k < 50; k++) begin
            @(posedge clock);
            if (beats_seen - s >= 2) break;
        end
        #3;
        reset = 1'b1;
        busy = 0;
        exp_q.delete();
        #1;
        chk("async_reset_rvalid", {63'd0, rvalid}, 64'd0);
        chk("beats_before_reset", 64'(beats_seen - s), 64'd2);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("post_reset_arready", {63'd0, arready}, 64'd1);
        issue_ar(BASE + 32'h10, 4'd12, 8'd0, 3'd3, 2'b01);
        wait_idle();

        z_old = 64'h0123_4567_89AB_CDEF;
        z_new = 64'hFEDC_BA98_7654_3210;
        @(posedge clock);
        #1 z_init_we = 1'b1; z_init_addr = BASE + 32'd40; z_init_data = z_old;
        @(posedge clock);
        #1;
        z_init_data = z_new;
        z_arvalid = 1'b1; z_araddr = BASE + 32'd40; z_arid = 4'd3;
        z_arlen = 8'd0; z_arsize = 3'd3; z_arburst = 2'b01;
        @(posedge clock);
        #1 z_arvalid = 1'b0; z_init_we = 1'b0;
        @(negedge clock);
        chk("lat0_rvalid", {63'd0, z_rvalid}, 64'd1);
        chk("lat0_old_data", z_rdata, z_old);
        chk("lat0_rside", {57'd0, z_rlast, z_rresp, z_rid}, {57'd0, 1'b1, 2'b00, 4'd3});
        @(posedge clock);
        #1 z_arvalid = 1'b1; z_arid = 4'd4;
        @(posedge clock);
        #1 z_arvalid = 1'b0;
        @(negedge clock);
        chk("lat0_rvalid2", {63'd0, z_rvalid}, 64'd1);
        chk("lat0_new_data", z_rdata, z_new);
        chk("lat0_rid2", {60'd0, z_rid}, 64'd4);
        repeat (2) @(posedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
